// File: rtl/iob_clint_seq_if.sv
// Command/response handshake plus the CLINT native bus, bundled for iob_clint_seq.
// The "master" modport is the sequencer's view; "slave" is the requester/CLINT side.
interface iob_clint_seq_if #(
    parameter int ADDR_W = 16
) ();
    logic              cmd_valid;
    logic              cmd_ready;
    logic [1:0]        cmd_op;
    logic [3:0]        cmd_hart;
    logic [63:0]       cmd_data;
    logic              rsp_valid;
    logic [63:0]       rsp_data;
    logic              rsp_err;
    logic              valid;
    logic [ADDR_W-1:0] address;
    logic [31:0]       wdata;
    logic [3:0]        wstrb;
    logic [31:0]       rdata;
    logic              ready;

    modport master (
        input  cmd_valid, cmd_op, cmd_hart, cmd_data, rdata, ready,
        output cmd_ready, rsp_valid, rsp_data, rsp_err, valid, address, wdata, wstrb
    );

    modport slave (
        output cmd_valid, cmd_op, cmd_hart, cmd_data, rdata, ready,
        input  cmd_ready, rsp_valid, rsp_data, rsp_err, valid, address, wdata, wstrb
    );
endinterface

// File: rtl/iob_clint_seq.sv
// Sequences CLINT register accesses: tear-free 64-bit mtime reads, glitch-free
// mtimecmp updates and MSIP set/clear, one command at a time.
module iob_clint_seq #(
    parameter int N_CORES   = 1,
    parameter int ADDR_W    = 16,
    parameter int MAX_RETRY = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    iob_clint_seq_if.master bus
);
    localparam logic [3:0] IDLE      = 4'd0;
    localparam logic [3:0] RD_HI1    = 4'd1;
    localparam logic [3:0] RD_LO     = 4'd2;
    localparam logic [3:0] RD_HI2    = 4'd3;
    localparam logic [3:0] WR_LO_MAX = 4'd4;
    localparam logic [3:0] WR_HI     = 4'd5;
    localparam logic [3:0] WR_LO     = 4'd6;
    localparam logic [3:0] WR_MSIP   = 4'd7;
    localparam logic [3:0] RESP      = 4'd8;

    localparam logic [1:0] OP_READ_TIME = 2'd0;
    localparam logic [1:0] OP_WRITE_CMP = 2'd1;
    localparam logic [1:0] OP_SET_MSIP  = 2'd2;

    localparam int RW = (MAX_RETRY > 1) ? $clog2(MAX_RETRY) : 1;

    localparam logic [ADDR_W-1:0] MTIME_LO = ADDR_W'(16'hBFF8);
    localparam logic [ADDR_W-1:0] MTIME_HI = ADDR_W'(16'hBFFC);
    localparam logic [ADDR_W-1:0] CMP_BASE = ADDR_W'(16'h4000);

    logic [3:0]    state_reg, state_next;
    logic [1:0]    op_reg, op_next;
    logic [3:0]    hart_reg, hart_next;
    logic [63:0]   data_reg, data_next;
    logic [31:0]   hi1_reg, hi1_next;
    logic [31:0]   lo_reg, lo_next;
    logic [RW-1:0] retry_reg, retry_next;
    logic [63:0]   rsp_data_reg, rsp_data_next;
    logic          rsp_err_reg, rsp_err_next;

    // Hart presence table; READ_TIME targets the shared mtime so it is never rejected.
    logic [15:0] hart_exists;
    generate
        for (genvar gi = 0; gi < 16; gi++) begin : g_hart
            assign hart_exists[gi] = (gi < N_CORES);
        end
    endgenerate

    always_comb begin
        state_next    = state_reg;
        op_next       = op_reg;
        hart_next     = hart_reg;
        data_next     = data_reg;
        hi1_next      = hi1_reg;
        lo_next       = lo_reg;
        retry_next    = retry_reg;
        rsp_data_next = rsp_data_reg;
        rsp_err_next  = rsp_err_reg;
        case (state_reg)
            IDLE: begin
                if (bus.cmd_valid) begin
                    op_next    = bus.cmd_op;
                    hart_next  = bus.cmd_hart;
                    data_next  = bus.cmd_data;
                    retry_next = '0;
                    if (bus.cmd_op == OP_READ_TIME) begin
                        state_next = RD_HI1;
                    end else if (!hart_exists[bus.cmd_hart]) begin
                        state_next    = RESP;
                        rsp_data_next = '0;
                        rsp_err_next  = 1'b1;
                    end else if (bus.cmd_op == OP_WRITE_CMP) begin
                        state_next = WR_LO_MAX;
                    end else begin
                        state_next = WR_MSIP;
                    end
                end
            end
            RD_HI1: if (bus.ready) begin
                hi1_next   = bus.rdata;
                state_next = RD_LO;
            end
            RD_LO: if (bus.ready) begin
                lo_next    = bus.rdata;
                state_next = RD_HI2;
            end
            RD_HI2: if (bus.ready) begin
                if (bus.rdata == hi1_reg) begin
                    state_next    = RESP;
                    rsp_data_next = {bus.rdata, lo_reg};
                    rsp_err_next  = 1'b0;
                end else if (retry_reg == RW'(MAX_RETRY - 1)) begin
                    state_next    = RESP;
                    rsp_data_next = {bus.rdata, lo_reg};
                    rsp_err_next  = 1'b1;
                end else begin
                    // Carry is settling: the fresh high word becomes the reference.
                    retry_next = retry_reg + 1'b1;
                    hi1_next   = bus.rdata;
                    state_next = RD_LO;
                end
            end
            WR_LO_MAX: if (bus.ready) state_next = WR_HI;
            WR_HI:     if (bus.ready) state_next = WR_LO;
            WR_LO, WR_MSIP: if (bus.ready) begin
                state_next    = RESP;
                rsp_data_next = '0;
                rsp_err_next  = 1'b0;
            end
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            op_reg       <= '0;
            hart_reg     <= '0;
            data_reg     <= '0;
            hi1_reg      <= '0;
            lo_reg       <= '0;
            retry_reg    <= '0;
            rsp_data_reg <= '0;
            rsp_err_reg  <= 1'b0;
        end else begin
            state_reg    <= state_next;
            op_reg       <= op_next;
            hart_reg     <= hart_next;
            data_reg     <= data_next;
            hi1_reg      <= hi1_next;
            lo_reg       <= lo_next;
            retry_reg    <= retry_next;
            rsp_data_reg <= rsp_data_next;
            rsp_err_reg  <= rsp_err_next;
        end
    end

    // Bus outputs decode straight from registered state, so reset drops them at once.
    logic              valid_d;
    logic [ADDR_W-1:0] address_d;
    logic [ADDR_W-1:0] cmp_addr;
    logic [31:0]       wdata_d;
    logic [3:0]        wstrb_d;

    always_comb begin
        valid_d   = 1'b0;
        address_d = '0;
        wdata_d   = '0;
        wstrb_d   = '0;
        cmp_addr  = CMP_BASE + ADDR_W'({hart_reg, 3'b000});
        case (state_reg)
            RD_HI1, RD_HI2: begin
                valid_d   = 1'b1;
                address_d = MTIME_HI;
            end
            RD_LO: begin
                valid_d   = 1'b1;
                address_d = MTIME_LO;
            end
            WR_LO_MAX: begin
                valid_d   = 1'b1;
                address_d = cmp_addr;
                wdata_d   = 32'hFFFF_FFFF;
                wstrb_d   = 4'hF;
            end
            WR_HI: begin
                valid_d   = 1'b1;
                address_d = cmp_addr + ADDR_W'(4);
                wdata_d   = data_reg[63:32];
                wstrb_d   = 4'hF;
            end
            WR_LO: begin
                valid_d   = 1'b1;
                address_d = cmp_addr;
                wdata_d   = data_reg[31:0];
                wstrb_d   = 4'hF;
            end
            WR_MSIP: begin
                valid_d   = 1'b1;
                address_d = ADDR_W'({hart_reg, 2'b00});
                wdata_d   = {31'b0, op_reg == OP_SET_MSIP};
                wstrb_d   = 4'hF;
            end
            default: ;
        endcase
    end

    assign bus.valid     = valid_d;
    assign bus.address   = address_d;
    assign bus.wdata     = wdata_d;
    assign bus.wstrb     = wstrb_d;
    assign bus.cmd_ready = (state_reg == IDLE);
    assign bus.rsp_valid = (state_reg == RESP);
    assign bus.rsp_data  = rsp_data_reg;
    assign bus.rsp_err   = rsp_err_reg;
endmodule

// File: tb/tb_iob_clint_seq.sv
// Directed bench for iob_clint_seq: a behavioural CLINT slave with configurable wait
// states and mtime-high behaviour, plus a linear sequence of commands.
module tb_iob_clint_seq;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    iob_clint_seq_if #(.ADDR_W(16)) bus_if ();

    iob_clint_seq #(.N_CORES(1), .ADDR_W(16), .MAX_RETRY(3)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus_if)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // CLINT slave model
    logic [63:0] mtime = 64'd0;
    logic [63:0] mtimecmp_m = '1;
    logic        msip_m = 1'b0;
    int          hi_mode = 0;
    int          hi_reads = 0;
    int          hi_base = 0;
    int          wait_cfg = 0;
    int          wait_cnt = 0;
    int          valid_cycles = 0;
    int          rsp_pulses = 0;
    logic        prev_pending = 1'b0;
    logic [51:0] prev_bus = '0;
    logic [15:0] log_addr[$];
    logic [31:0] log_wdata[$];
    logic [3:0]  log_wstrb[$];
    logic [31:0] rdata_v;
    logic        mtip;

    assign mtip = (mtime >= mtimecmp_m);
    assign bus_if.ready = bus_if.valid && (wait_cnt >= wait_cfg);
    assign bus_if.rdata = rdata_v;

    always_comb begin
        rdata_v = 32'd0;
        if (bus_if.address == 16'hBFF8) rdata_v = mtime[31:0];
        else if (bus_if.address == 16'hBFFC) begin
            case (hi_mode)
                1:       rdata_v = (hi_reads == hi_base) ? 32'd1 : 32'd2;
                2:       rdata_v = 32'(hi_reads - hi_base);
                default: rdata_v = mtime[63:32];
            endcase
        end
    end

    always @(posedge clk) begin
        if (bus_if.valid) valid_cycles <= valid_cycles + 1;
        if (bus_if.rsp_valid) rsp_pulses <= rsp_pulses + 1;
        if (bus_if.valid && prev_pending)
            check("bus_stable", 64'({bus_if.address, bus_if.wdata, bus_if.wstrb}), 64'(prev_bus));
        prev_pending <= bus_if.valid && !bus_if.ready;
        prev_bus     <= {bus_if.address, bus_if.wdata, bus_if.wstrb};
        if (bus_if.valid && !bus_if.ready) wait_cnt <= wait_cnt + 1;
        else wait_cnt <= 0;
        if (bus_if.valid && bus_if.ready) begin
            log_addr.push_back(bus_if.address);
            log_wdata.push_back(bus_if.wdata);
            log_wstrb.push_back(bus_if.wstrb);
            if (bus_if.wstrb == 4'hF) begin
                if (bus_if.address == 16'h0000) msip_m <= bus_if.wdata[0];
                if (bus_if.address == 16'h4000) mtimecmp_m[31:0] <= bus_if.wdata;
                if (bus_if.address == 16'h4004) mtimecmp_m[63:32] <= bus_if.wdata;
            end else if (bus_if.address == 16'hBFFC) begin
                hi_reads <= hi_reads + 1;
            end
        end
    end

    // Issue one command, then check latency, response, one-cycle pulse and held data.
    task automatic run_cmd(input string tag, input logic [1:0] op, input logic [3:0] hart,
                           input logic [63:0] data, input int exp_lat,
                           input logic [63:0] exp_data, input logic exp_err);
        int lat;
        @(negedge clk);
        bus_if.cmd_valid = 1'b1;
        bus_if.cmd_op    = op;
        bus_if.cmd_hart  = hart;
        bus_if.cmd_data  = data;
        @(posedge clk);
        #1;
        bus_if.cmd_valid = 1'b0;
        check({tag, "_busy"}, 64'(bus_if.cmd_ready), 64'd0);
        lat = 1;
        while (!bus_if.rsp_valid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
        check({tag, "_data"}, bus_if.rsp_data, exp_data);
        check({tag, "_err"}, 64'(bus_if.rsp_err), 64'(exp_err));
        @(posedge clk);
        #1;
        check({tag, "_pulse"}, 64'(bus_if.rsp_valid), 64'd0);
        check({tag, "_hold"}, bus_if.rsp_data, exp_data);
        $display("cmd %s op=%0d hart=%0d data=%h -> rsp_data=%h err=%0b lat=%0d",
                 tag, op, hart, data, exp_data, exp_err, lat);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int lb, vb, pb;
        logic found;
        bus_if.cmd_valid = 1'b0;
        bus_if.cmd_op    = 2'd0;
        bus_if.cmd_hart  = 4'd0;
        bus_if.cmd_data  = 64'd0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_valid", 64'(bus_if.valid), 64'd0);
        check("rst_addr", 64'(bus_if.address), 64'd0);
        check("rst_wdata", 64'(bus_if.wdata), 64'd0);
        check("rst_wstrb", 64'(bus_if.wstrb), 64'd0);
        check("rst_rsp_valid", 64'(bus_if.rsp_valid), 64'd0);
        check("rst_rsp_data", bus_if.rsp_data, 64'd0);
        check("rst_rsp_err", 64'(bus_if.rsp_err), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_cmd_ready", 64'(bus_if.cmd_ready), 64'd1);

        // READ_TIME, stable mtime
        mtime = 64'h0000_0001_0000_0010;
        hi_mode = 0;
        lb = log_addr.size();
        run_cmd("rd_stable", 2'd0, 4'd0, 64'd0, 4, 64'h0000_0001_0000_0010, 1'b0);
        check("rd_stable_n", 64'(log_addr.size() - lb), 64'd3);
        check("rd_stable_a0", 64'(log_addr[lb]), 64'hBFFC);
        check("rd_stable_a1", 64'(log_addr[lb+1]), 64'hBFF8);
        check("rd_stable_a2", 64'(log_addr[lb+2]), 64'hBFFC);
        check("rd_stable_strb", 64'({log_wstrb[lb], log_wstrb[lb+1], log_wstrb[lb+2]}), 64'd0);

        // READ_TIME with hi rolling 1->2: exactly one retry
        hi_base = hi_reads;
        hi_mode = 1;
        lb = log_addr.size();
        run_cmd("rd_roll", 2'd0, 4'd0, 64'd0, 6, 64'h0000_0002_0000_0010, 1'b0);
        check("rd_roll_n", 64'(log_addr.size() - lb), 64'd5);

        // READ_TIME with hi changing on every read: error after 3 mismatches
        hi_base = hi_reads;
        hi_mode = 2;
        lb = log_addr.size();
        run_cmd("rd_unstable", 2'd0, 4'd0, 64'd0, 8, 64'h0000_0003_0000_0010, 1'b1);
        check("rd_unstable_n", 64'(log_addr.size() - lb), 64'd7);

        // READ_TIME ignores the hart index
        hi_mode = 0;
        run_cmd("rd_hart7", 2'd0, 4'd7, 64'd0, 4, 64'h0000_0001_0000_0010, 1'b0);

        // WRITE_CMP hart0 = 20
        mtime = 64'd0;
        lb = log_addr.size();
        run_cmd("wr_cmp", 2'd1, 4'd0, 64'd20, 4, 64'd0, 1'b0);
        check("wr_cmp_n", 64'(log_addr.size() - lb), 64'd3);
        check("wr_cmp_a", 64'({log_addr[lb], log_addr[lb+1], log_addr[lb+2]}), 64'h4000_4004_4000);
        check("wr_cmp_d0", 64'(log_wdata[lb]), 64'hFFFF_FFFF);
        check("wr_cmp_d1", 64'(log_wdata[lb+1]), 64'd0);
        check("wr_cmp_d2", 64'(log_wdata[lb+2]), 64'd20);
        check("wr_cmp_strb", 64'({log_wstrb[lb], log_wstrb[lb+1], log_wstrb[lb+2]}), 64'hFFF);
        mtime = 64'd19;
        #1;
        check("mtip_19", 64'(mtip), 64'd0);
        mtime = 64'd20;
        #1;
        check("mtip_20", 64'(mtip), 64'd1);

        // SET_MSIP / CLR_MSIP hart0
        lb = log_addr.size();
        run_cmd("set_msip", 2'd2, 4'd0, 64'd0, 2, 64'd0, 1'b0);
        check("set_msip_bus", 64'({log_addr[lb], log_wdata[lb], log_wstrb[lb]}), 64'({16'h0, 32'd1, 4'hF}));
        check("set_msip_bit", 64'(msip_m), 64'd1);
        lb = log_addr.size();
        run_cmd("clr_msip", 2'd3, 4'd0, 64'd0, 2, 64'd0, 1'b0);
        check("clr_msip_bus", 64'({log_addr[lb], log_wdata[lb], log_wstrb[lb]}), 64'({16'h0, 32'd0, 4'hF}));
        check("clr_msip_bit", 64'(msip_m), 64'd0);

        // Slow slave: three wait cycles per access
        wait_cfg = 3;
        lb = log_addr.size();
        run_cmd("wr_slow", 2'd1, 4'd0, 64'h1234_5678_9ABC_DEF0, 13, 64'd0, 1'b0);
        check("wr_slow_d", 64'({log_wdata[lb+1], log_wdata[lb+2]}), 64'h1234_5678_9ABC_DEF0);
        check("wr_slow_cmp", mtimecmp_m, 64'h1234_5678_9ABC_DEF0);

        // Out-of-range hart: immediate error, no bus traffic
        vb = valid_cycles;
        run_cmd("msip_bad_hart", 2'd2, 4'd1, 64'd0, 1, 64'd0, 1'b1);
        check("msip_bad_hart_nobus", 64'(valid_cycles - vb), 64'd0);
        run_cmd("cmp_bad_hart", 2'd1, 4'd15, 64'd5, 1, 64'd0, 1'b1);

        // Reset during WR_HI
        pb = rsp_pulses;
        @(negedge clk);
        bus_if.cmd_valid = 1'b1;
        bus_if.cmd_op    = 2'd1;
        bus_if.cmd_hart  = 4'd0;
        bus_if.cmd_data  = 64'h0000_00AA_0000_00BB;
        @(posedge clk);
        #1;
        bus_if.cmd_valid = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            if (bus_if.valid && bus_if.address == 16'h4004) found = 1'b1;
            else begin
                @(posedge clk);
                #1;
            end
        end
        check("rst_mid_reach_wr_hi", 64'(found), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_mid_valid", 64'(bus_if.valid), 64'd0);
        check("rst_mid_addr", 64'({bus_if.address, bus_if.wdata, bus_if.wstrb}), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        check("rst_mid_no_rsp", 64'(rsp_pulses - pb), 64'd0);
        check("rst_mid_cmd_ready", 64'(bus_if.cmd_ready), 64'd1);
        check("rst_mid_rsp_data", bus_if.rsp_data, 64'd0);
        $display("cmd rst_mid op=1 hart=0 abandoned by reset during WR_HI");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/iob_clint_seq.md
IOB_CLINT_SEQ -- requirements
Module: iob_clint_seq

Interface
REQ-001 SHALL have parameter N_CORES, default 1, number of harts served (1..16).
REQ-002 SHALL have parameter ADDR_W, default 16, CLINT bus address width.
REQ-003 SHALL have parameter MAX_RETRY, default 3, the number of mtime re-read attempts before error.
REQ-004 SHALL have port clk  in  1  sole clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_n  in  1  asynchronous, active-low reset.
REQ-006 SHALL have port cmd_valid  in  1  command request.
REQ-007 SHALL have port cmd_ready  out  1  command accepted when cmd_valid & cmd_ready.
REQ-008 SHALL have port cmd_op  in  2  0=READ_TIME, 1=WRITE_CMP, 2=SET_MSIP, 3=CLR_MSIP.
REQ-009 SHALL have port cmd_hart  in  4  target hart index.
REQ-010 SHALL have port cmd_data  in  64  mtimecmp value for WRITE_CMP.
REQ-011 SHALL have port rsp_valid  out  1  one-cycle completion pulse.
REQ-012 SHALL have port rsp_data  out  64  mtime value for READ_TIME, else 0.
REQ-013 SHALL have port rsp_err  out  1  error flag, qualified by rsp_valid.
REQ-014 SHALL have ports valid, address[ADDR_W], wdata[32], wstrb[4] (out) and rdata[32], ready (in) forming the CLINT native bus master.

Function
REQ-015 Address map SHALL be MSIP 0+4*hart, MTIMECMP 16384+8*hart (lo) / +4 (hi), MTIME 49144 (lo) / 49148 (hi).
REQ-016 cmd_ready SHALL be 1 only in IDLE; commands are captured (op, hart, data) on acceptance.
REQ-017 FSM states SHALL be IDLE, RD_HI1, RD_LO, RD_HI2, WR_LO_MAX, WR_HI, WR_LO, WR_MSIP, RESP.
REQ-018 In every access state, valid SHALL be 1 with stable address/wdata/wstrb until a cycle with ready=1; the access completes that edge and the FSM advances next cycle.
REQ-019 Reads SHALL drive wstrb=0, wdata=0; writes SHALL drive wstrb=4'hF; rdata SHALL be captured on the completing edge.
REQ-020 Outside access states, valid SHALL be 0; address, wdata and wstrb SHALL be 0.
REQ-021 READ_TIME SHALL run RD_HI1 -> RD_LO -> RD_HI2; if HI2==HI1 it SHALL go to RESP with rsp_data={HI2,LO}, else retry from RD_LO using HI2 as new HI1.
REQ-022 After MAX_RETRY consecutive mismatches, READ_TIME SHALL end with rsp_err=1 and the last {HI2,LO}.
REQ-023 WRITE_CMP SHALL run WR_LO_MAX (lo=32'hFFFFFFFF) -> WR_HI (cmd_data[63:32]) -> WR_LO (cmd_data[31:0]) -> RESP.
REQ-024 SET_MSIP/CLR_MSIP SHALL write 1/0 to the hart's MSIP word in WR_MSIP -> RESP.
REQ-025 cmd_hart >= N_CORES on any op except READ_TIME SHALL go IDLE -> RESP directly with rsp_err=1 and no bus access.
REQ-026 RESP SHALL last exactly one cycle (rsp_valid=1), then return to IDLE; rsp_data/rsp_err SHALL hold until the next RESP.
REQ-027 Latency with zero-wait slave (ready high whenever valid): READ_TIME rsp_valid 4 cycles after the acceptance edge, WRITE_CMP 4, MSIP 2, error 1.
REQ-028 cmd_valid while busy SHALL be ignored (not queued); the master must hold it.

Reset
REQ-029 rst_n=0 SHALL immediately force IDLE, cmd_ready=1 after release, valid=0, address=0, wdata=0, wstrb=0, rsp_valid=0, rsp_data=0, rsp_err=0, retry count=0.
REQ-030 Reset mid-transaction SHALL abandon it without a response; the outstanding bus access is dropped (valid deasserted asynchronously).

Verification
REQ-031 READ_TIME, mtime=64'h0000_0001_0000_0010 stable, zero-wait -> reads 49148, 49144, 49148; rsp_data=64'h1_0000_0010, rsp_err=0, rsp_valid 4 cycles after accept.
REQ-032 READ_TIME with hi rolling 1->2 between HI1 and HI2 -> exactly one retry; rsp_data={2,lo}, rsp_err=0; with hi changing on every read -> rsp_err=1 after 3 retries.
REQ-033 WRITE_CMP hart0 data=20 -> writes 16384<=FFFFFFFF, 16388<=0, 16384<=20 in order, wstrb=F; CLINT mtip rises once mtime>=20.
REQ-034 SET_MSIP hart0 then CLR_MSIP -> write 0<=1, msip[0]=1; then 0<=0, msip[0]=0.
REQ-035 Slave with ready delayed 3 cycles per access -> valid/address stable throughout, WRITE_CMP completes in 13 cycles; SET_MSIP hart=N_CORES -> rsp_err=1, valid never asserted.
REQ-036 rst_n pulsed low during WR_HI -> valid=0 immediately, no rsp_valid, cmd_ready=1 after release.
